sram_bank_ctrl: RTL and testbench

- Parametrised single-port on-chip RAM bank with a valid/ready request channel and a registered valid/ready response channel.
- Supports byte-enabled writes, per-word "written" tracking so reads return zero after reset, out-of-range error responses and a saturating error counter.
- Successor to the fixed 16-bit × 2048 RAM.
- Sits between bus masters (core/DMA) and local storage as a drop-in bank.

---
 rtl/sram_bank_ctrl.sv | 110 +++++++++++
 tb/tb_sram_bank_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_ctrl.sv
// rtl/sram_bank_ctrl.sv - single-port RAM bank with valid/ready request and registered response
// Optional per-byte even parity storage and read check when SRAM_PARITY_EN is defined.
module sram_bank_ctrl #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 2048,
   parameter int ADDR_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_error,
   output logic                rsp_perr,
   output logic [15:0]         err_count
);
   localparam int NB = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  written;
   logic [IDX_W-1:0]  idx;
   logic              accept;
   logic              in_range;
   logic              wr_en;
   logic [DATA_W-1:0] rd_word;

   assign req_ready = !rsp_valid || rsp_ready;
   assign accept    = req_valid && req_ready;
   assign in_range  = {1'b0, req_addr} < DEPTH_X;
   assign idx       = req_addr[IDX_W-1:0];
   assign wr_en     = accept && req_write && in_range && (req_be != '0);
   assign rd_word   = written[idx] ? mem[idx] : '0;

   // First write to a word zero-fills its disabled bytes so they later read as 0.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (req_be[i])
               mem[idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
            else if (!written[idx])
               mem[idx][i*8 +: 8] <= 8'h00;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
         err_count <= '0;
         written   <= '0;
      end else begin
         if (wr_en)
            written[idx] <= 1'b1;
         if (accept) begin
            rsp_valid <= 1'b1;
            rsp_error <= !in_range;
            rsp_rdata <= (!req_write && in_range) ? rd_word : '0;
            if (!in_range && err_count != 16'hFFFF)
               err_count <= err_count + 16'd1;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifdef SRAM_PARITY_EN
   logic [NB-1:0] par [DEPTH];
   logic [NB-1:0] rd_par;
   logic          perr_now;

   always_comb begin
      rd_par = '0;
      for (int i = 0; i < NB; i++)
         rd_par[i] = ^mem[idx][i*8 +: 8];
   end

   assign perr_now = written[idx] && (rd_par != par[idx]);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (req_be[i])
               par[idx][i] <= ^req_wdata[i*8 +: 8];
            else if (!written[idx])
               par[idx][i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rsp_perr <= 1'b0;
      else if (accept)
         rsp_perr <= !req_write && in_range && perr_now;
   end
`else
   assign rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// tb/tb_sram_bank_ctrl.sv - self-checking bench for sram_bank_ctrl
module tb_sram_bank_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [1:0]  req_be = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_rdata;
   logic        rsp_error;
   logic        rsp_perr;
   logic [15:0] err_count;

   int n_checks = 0;
   int n_fail = 0;

   sram_bank_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .rsp_perr(rsp_perr), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bank contents, written flags, one pending response.
   logic [15:0] m_mem [2048];
   bit          m_wr [2048];
   bit          m_valid;
   logic [15:0] m_rdata;
   bit          m_error;
   int          m_err;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid = 0; m_rdata = '0; m_error = 0; m_err = 0;
         for (int i = 0; i < 2048; i++) m_wr[i] = 0;
      end else if (req_valid && (!m_valid || rsp_ready)) begin
         m_valid = 1;
         m_rdata = '0;
         m_error = 0;
         if (req_addr >= 16'd2048) begin
            m_error = 1;
            if (m_err < 65535) m_err++;
         end else if (req_write) begin
            if (req_be != 2'b00) begin
               if (!m_wr[req_addr]) m_mem[req_addr] = '0;
               if (req_be[0]) m_mem[req_addr][7:0]  = req_wdata[7:0];
               if (req_be[1]) m_mem[req_addr][15:8] = req_wdata[15:8];
               m_wr[req_addr] = 1;
            end
         end else begin
            m_rdata = m_wr[req_addr] ? m_mem[req_addr] : 16'h0000;
         end
      end else if (rsp_ready) begin
         m_valid = 0;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rsp_valid", rsp_valid, m_valid);
         chk("req_ready", req_ready, !m_valid || rsp_ready);
         chk("err_count", err_count, m_err);
         chk("rsp_perr", rsp_perr, 1'b0);
         if (m_valid) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_error", rsp_error, m_error);
         end
      end
   end

   // Present a request and hold it until accepted; returns 2 time units after the accepting edge.
   task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
      bit ok;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      for (int n = 0; n < 20; n++) begin
         #1;
         ok = req_ready;
         @(posedge clk);
         #2;
         if (ok) return;
      end
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: request addr %h never accepted", a);
   endtask

   task automatic idle();
      req_valid = 1'b0;
      @(posedge clk);
      #2;
   endtask

   task automatic read_expect(input string name, input logic [15:0] a, input logic [15:0] exp, input logic err);
      do_req(1'b0, a, 16'h0, 2'b00);
      chk({name, "_valid"}, rsp_valid, 1'b1);
      chk({name, "_rdata"}, rsp_rdata, exp);
      chk({name, "_error"}, rsp_error, err);
   endtask

   initial begin
      #3;
      chk("reset_rsp_valid", rsp_valid, 1'b0);
      chk("reset_err_count", err_count, 16'h0);
      chk("reset_rsp_rdata", rsp_rdata, 16'h0);
      #19 rst = 1'b1;
      chk("req_ready_after_reset", req_ready, 1'b1);

      read_expect("rd5_after_reset", 16'd5, 16'h0000, 1'b0);
      chk("err_count_initial", err_count, 16'h0);

      do_req(1'b1, 16'd1, 16'hABCD, 2'b11);
      do_req(1'b1, 16'd1, 16'h1234, 2'b01);
      read_expect("be_merge", 16'd1, 16'hAB34, 1'b0);

      do_req(1'b1, 16'd2047, 16'd40, 2'b11);
      read_expect("rd_top", 16'd2047, 16'd40, 1'b0);
      do_req(1'b1, 16'd0, 16'd10, 2'b11);
      read_expect("rd_zero", 16'd0, 16'd10, 1'b0);

      do_req(1'b1, 16'd6, 16'h5566, 2'b10);
      read_expect("partial_first_write", 16'd6, 16'h5500, 1'b0);
      do_req(1'b1, 16'd7, 16'h9999, 2'b00);
      read_expect("be_none", 16'd7, 16'h0000, 1'b0);
      idle();

      read_expect("oor_read", 16'd2048, 16'h0000, 1'b1);
      do_req(1'b1, 16'd2048, 16'hFFFF, 2'b11);
      chk("oor_write_error", rsp_error, 1'b1);
      chk("oor_write_rdata", rsp_rdata, 16'h0);
      chk("err_count_two", err_count, 16'd2);
      read_expect("no_alias", 16'd0, 16'd10, 1'b0);
      read_expect("oor_max", 16'hFFFF, 16'h0000, 1'b1);
      chk("err_count_three", err_count, 16'd3);
      idle();

      do_req(1'b1, 16'd2, 16'd20, 2'b11);
      idle();
      rsp_ready = 1'b0;
      do_req(1'b0, 16'd2, 16'h0, 2'b00);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd8; req_wdata = 16'd88; req_be = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2;
         chk("bp_rdata", rsp_rdata, 16'd20);
         chk("bp_valid", rsp_valid, 1'b1);
         chk("bp_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      #1 chk("bp_release_ready", req_ready, 1'b1);
      @(posedge clk);
      #2;
      chk("bp_new_valid", rsp_valid, 1'b1);
      chk("bp_new_rdata", rsp_rdata, 16'h0);
      req_valid = 1'b0;
      read_expect("rd8", 16'd8, 16'd88, 1'b0);
      idle();

      rsp_ready = 1'b0;
      do_req(1'b1, 16'd3, 16'd7, 2'b11);
      req_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("midreset_valid", rsp_valid, 1'b0);
      chk("midreset_err_count", err_count, 16'h0);
      @(posedge clk);
      #3 rst = 1'b1;
      rsp_ready = 1'b1;
      read_expect("after_reset_rd3", 16'd3, 16'h0000, 1'b0);
      read_expect("after_reset_rd1", 16'd1, 16'h0000, 1'b0);
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
